stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control FSM and timebase for the stopwatch: it turns the two user buttons into start/stop/lap/reset commands and sequences the time counter and display latch. A prescaler generates the 0.01 s increment strobe. The block runs on the system clock with the reset output of the reset synchronizer. It drives the time counter (`cnt_clr`, `cnt_inc`) and the display path (`disp_load`, `disp_hold`).

## Interface
- `DIV`, default 1_000_000: clock cycles per 0.01 s tick (100 MHz clk). Legal range 2 ≤ `DIV` ≤ 2^`DIV_W`.
- `DIV_W`, default 20: prescaler width.
- `clk`  in  1  system clock; all state on rising edge.
- `rstb`  in  1  asynchronous, active-low reset; driven by the reset synchronizer output.
- `btn_ss`  in  1  start/stop button level; already synchronized and debounced by the caller.
- `btn_lr`  in  1  lap/reset button level; already synchronized and debounced by the caller.
- `cnt_clr`  out  1  one-cycle pulse: clear time counter to 0.
- `cnt_inc`  out  1  one-cycle pulse: advance time counter by 0.01 s.
- `disp_load`  out  1  one-cycle pulse: capture time counter into display latch.
- `disp_hold`  out  1  1 = display shows latched lap value; 0 = display tracks counter live.
- `state`  out  2  current FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

## Operation
**Press detection**
- Registers `ss_q` and `lr_q` hold the previous sample of each button.
- A press is `btn & ~btn_q`, so each press yields exactly one event.
- `ss_q` and `lr_q` reset to 1. A button held through reset release produces no event until it is released and pressed again.

**FSM** (transitions occur at the edge where the press is detected)
- IDLE:
  - ss → RUN.
  - lr → stay in IDLE and pulse `cnt_clr`.
- RUN:
  - ss → PAUSE.
  - lr → LAP, pulse `disp_load`.
- LAP:
  - ss → PAUSE.
  - lr → RUN.
  - The counter keeps running in LAP.
- PAUSE:
  - ss → RUN.
  - lr → IDLE, pulse `cnt_clr`, clear prescaler.
- Simultaneous ss and lr press in the same cycle: ss wins, lr is discarded, and no lr-side pulse is generated.

**Prescaler `pre`** (`DIV_W` bits)
- In RUN or LAP: increments each cycle.
  - When `pre == DIV-1`, it wraps to 0 and `cnt_inc` pulses.
- In PAUSE: holds its value, so the sub-tick fraction is preserved across a pause.
- In IDLE: forced to 0.
- A wrap on the same edge as an ss press leaving RUN/LAP is honored: `cnt_inc` pulses, `pre` becomes 0, and state becomes PAUSE.

**Display hold**
- `disp_hold` = 1 exactly when state = LAP.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Edge E is the first edge at which a button samples 1. At E the state updates, so `state`, `disp_hold`, and any `cnt_clr`/`disp_load` pulse are visible in the cycle following E.
- `cnt_inc`, `cnt_clr`, and `disp_load` are each high for exactly one cycle per event.
- In continuous RUN, `cnt_inc` period = `DIV` cycles.
  - Entry from IDLE: the first `cnt_inc` is high in the cycle after the `DIV`-th edge following the RUN-entry edge.
- `rstb` low asynchronously forces: state = IDLE, `pre` = 0, `cnt_clr` = `cnt_inc` = `disp_load` = `disp_hold` = 0, `ss_q` = `lr_q` = 1.
  - This applies mid-operation, including mid-pulse.
  - Deassertion is already synchronized upstream.

## Test plan
Use `DIV=4` and `DIV_W=3` for simulation.
1. **Held button through reset:** hold `btn_ss`=1 and release `rstb` → `state` stays 00 and all outputs stay 0. Drop `btn_ss` for 1 cycle and raise it again → `state`=01 in the cycle after the sampling edge.
2. **Tick rate:** from IDLE press ss, then hold 12 cycles → exactly 3 `cnt_inc` pulses, spaced 4 cycles apart, no other pulses.
3. **Lap:** in RUN press lr → one `disp_load` pulse, `disp_hold`=1, `state`=11, `cnt_inc` continues every 4 cycles. Press lr again → `disp_hold`=0, `state`=01, no `disp_load`.
4. **Pause preserves fraction:** pause with `pre`=2, wait 100 cycles → no `cnt_inc`. Resume → first `cnt_inc` is high in the cycle after the 2nd edge following the resume edge.
5. **Simultaneous press, then reset:** in RUN press ss and lr in the same cycle → `state`=10, no `disp_load`. Then press lr → `state`=00, one `cnt_clr` pulse, `pre`=0.
6. **Async reset mid-operation:** during RUN, while `cnt_inc` is high, drop `rstb` between clock edges → all outputs 0 and `state`=00 immediately. Release → `state` stays IDLE.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button press detection, start/stop/lap/reset FSM and the
// 0.01 s prescaler that strobes the time counter. All outputs are registered.
module stopwatch_ctrl #(
    parameter int DIV   = 1_000_000,
    parameter int DIV_W = 20
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       cnt_clr,
    output logic       cnt_inc,
    output logic       disp_load,
    output logic       disp_hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(DIV - 1);

    state_t           st, st_nxt;
    logic [DIV_W-1:0] pre, pre_nxt;
    logic             ss_q, lr_q;
    logic             ss_press, lr_press;
    logic             running, wrap;
    logic             clr_nxt, load_nxt;

    // Rising-edge detect; ss has priority so a simultaneous lr is dropped.
    assign ss_press = btn_ss & ~ss_q;
    assign lr_press = btn_lr & ~lr_q & ~ss_press;

    // The tick is decided on the current state, so a wrap on the same edge
    // that leaves RUN/LAP still produces its strobe.
    assign running = (st == RUN) || (st == LAP);
    assign wrap    = running && (pre == PRE_MAX);

    assign state = st;

    // Next-state, command pulses and prescaler update.
    always_comb begin
        st_nxt   = st;
        clr_nxt  = 1'b0;
        load_nxt = 1'b0;
        pre_nxt  = pre;
        case (st)
            IDLE: begin
                if (ss_press)      st_nxt = RUN;
                else if (lr_press) clr_nxt = 1'b1;
            end
            RUN: begin
                if (ss_press) st_nxt = PAUSE;
                else if (lr_press) begin
                    st_nxt   = LAP;
                    load_nxt = 1'b1;
                end
            end
            LAP: begin
                if (ss_press)      st_nxt = PAUSE;
                else if (lr_press) st_nxt = RUN;
            end
            PAUSE: begin
                if (ss_press) st_nxt = RUN;
                else if (lr_press) begin
                    st_nxt  = IDLE;
                    clr_nxt = 1'b1;
                end
            end
            default: st_nxt = IDLE;
        endcase

        // Pause keeps the sub-tick fraction; IDLE (or the reset command) zeroes it.
        if (st == IDLE || clr_nxt) pre_nxt = '0;
        else if (running)          pre_nxt = wrap ? '0 : pre + DIV_W'(1);
    end

    // FSM state, prescaler and button history.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            st   <= IDLE;
            pre  <= '0;
            ss_q <= 1'b1;
            lr_q <= 1'b1;
        end else begin
            st   <= st_nxt;
            pre  <= pre_nxt;
            ss_q <= btn_ss;
            lr_q <= btn_lr;
        end
    end

    // Registered output pulses and display hold flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_clr   <= 1'b0;
            cnt_inc   <= 1'b0;
            disp_load <= 1'b0;
            disp_hold <= 1'b0;
        end else begin
            cnt_clr   <= clr_nxt;
            cnt_inc   <= wrap;
            disp_load <= load_nxt;
            disp_hold <= (st_nxt == LAP);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// checked against a behavioural model that tracks elapsed running cycles.
module tb_stopwatch_ctrl;

    localparam int DIV   = 4;
    localparam int DIV_W = 3;

    logic       clk, rstb, btn_ss, btn_lr;
    logic       cnt_clr, cnt_inc, disp_load, disp_hold;
    logic [1:0] state;
    logic [5:0] obs;

    int n_chk  = 0;
    int n_pass = 0;

    stopwatch_ctrl #(.DIV(DIV), .DIV_W(DIV_W)) dut (
        .clk(clk), .rstb(rstb), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .cnt_clr(cnt_clr), .cnt_inc(cnt_inc), .disp_load(disp_load),
        .disp_hold(disp_hold), .state(state)
    );

    assign obs = {state, disp_hold, disp_load, cnt_clr, cnt_inc};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // m_elapsed counts running cycles since the last clear; a tick is due
    // every time it reaches a multiple of DIV.
    logic [1:0] m_st;
    logic       m_pss, m_plr, m_inc, m_clr, m_load, m_hold;
    int         m_elapsed;
    logic [5:0] m_vec;

    task automatic model_reset();
        m_st = 2'b00; m_pss = 1'b1; m_plr = 1'b1; m_elapsed = 0;
        m_inc = 0; m_clr = 0; m_load = 0; m_hold = 0;
        m_vec = '0;
    endtask

    task automatic model_step(input logic ss, input logic lr);
        logic ss_ev, lr_ev;
        ss_ev = ss && !m_pss;
        lr_ev = lr && !m_plr && !ss_ev;
        m_pss = ss; m_plr = lr;
        m_inc = 0; m_clr = 0; m_load = 0;
        if (m_st == 2'b01 || m_st == 2'b11) begin
            m_elapsed++;
            m_inc = (m_elapsed % DIV) == 0;
        end
        case (m_st)
            2'b00: if (ss_ev) m_st = 2'b01; else if (lr_ev) m_clr = 1;
            2'b01: if (ss_ev) m_st = 2'b10; else if (lr_ev) begin m_st = 2'b11; m_load = 1; end
            2'b11: if (ss_ev) m_st = 2'b10; else if (lr_ev) m_st = 2'b01;
            default: if (ss_ev) m_st = 2'b01;
                     else if (lr_ev) begin m_st = 2'b00; m_clr = 1; m_elapsed = 0; end
        endcase
        m_hold = (m_st == 2'b11);
        m_vec  = {m_st, m_hold, m_load, m_clr, m_inc};
    endtask

    // Drive buttons after a falling edge, clock once, land on the next falling edge.
    task automatic step(input logic ss, input logic lr);
        btn_ss = ss; btn_lr = lr;
        @(posedge clk);
        model_step(ss, lr);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstb = 1'b0; btn_ss = 1'b1; btn_lr = 1'b0;
        model_reset();
        @(negedge clk);
        n_chk++; if (obs !== 6'b0) $display("FAIL reset_outputs: got %b want %b", obs, 6'b0); else n_pass++;
        rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            n_chk++; if (obs !== 6'b0) $display("FAIL held_ss_no_event: got %b want %b", obs, 6'b0); else n_pass++;
        end
        step(0, 0);
        step(1, 0);
        n_chk++; if (state !== 2'b01) $display("FAIL repress_run: got %b want 01", state); else n_pass++;
        n_chk++; if (obs !== m_vec) $display("FAIL repress_model: got %b want %b", obs, m_vec); else n_pass++;
    endtask

    task automatic test_tick();
        int pos[$];
        step(0, 0); step(1, 0);   // RUN -> PAUSE
        step(0, 0); step(0, 1);   // PAUSE -> IDLE
        step(0, 0);
        step(1, 0);               // IDLE -> RUN
        for (int i = 1; i <= 12; i++) begin
            step(1, 0);
            if (cnt_inc) pos.push_back(i);
            n_chk++; if (obs !== m_vec) $display("FAIL tick_model: got %b want %b", obs, m_vec); else n_pass++;
        end
        n_chk++; if (pos.size() != 3) $display("FAIL tick_count: got %0d want 3", pos.size()); else n_pass++;
        n_chk++;
        if (pos.size() != 3 || pos[0] != 4 || pos[1] != 8 || pos[2] != 12)
            $display("FAIL tick_spacing: got %p want 4,8,12", pos);
        else n_pass++;
    endtask

    task automatic test_lap();
        int incs = 0;
        step(0, 0);
        step(0, 1);
        n_chk++; if (obs[5:2] !== 4'b1111) $display("FAIL lap_enter: got %b want 1111", obs[5:2]); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            incs += int'(cnt_inc);
            n_chk++; if (obs !== m_vec) $display("FAIL lap_model: got %b want %b", obs, m_vec); else n_pass++;
        end
        n_chk++; if (incs != 2) $display("FAIL lap_incs: got %0d want 2", incs); else n_pass++;
        step(0, 1);
        n_chk++; if (obs[5:2] !== 4'b0100) $display("FAIL lap_exit: got %b want 0100", obs[5:2]); else n_pass++;
    endtask

    task automatic test_pause();
        int  incs = 0;
        bit  seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step(0, 0);
            seen = cnt_inc;
        end
        n_chk++; if (!seen) $display("FAIL pause_sync_timeout: got none want cnt_inc"); else n_pass++;
        step(0, 0);
        step(1, 0);
        n_chk++; if (state !== 2'b10) $display("FAIL pause_state: got %b want 10", state); else n_pass++;
        n_chk++; if (dut.pre !== 3'd2) $display("FAIL pause_pre: got %0d want 2", dut.pre); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            step(0, 0);
            incs += int'(cnt_inc);
        end
        n_chk++; if (incs != 0) $display("FAIL pause_no_inc: got %0d want 0", incs); else n_pass++;
        step(1, 0);
        step(0, 0);
        n_chk++; if (cnt_inc !== 1'b0) $display("FAIL resume_early: got %b want 0", cnt_inc); else n_pass++;
        step(0, 0);
        n_chk++; if (cnt_inc !== 1'b1) $display("FAIL resume_inc: got %b want 1", cnt_inc); else n_pass++;
    endtask

    task automatic test_simul_then_clear();
        step(0, 0);
        step(1, 1);
        n_chk++; if (state !== 2'b10 || disp_load !== 1'b0)
            $display("FAIL simul_press: got st=%b load=%b want st=10 load=0", state, disp_load);
        else n_pass++;
        step(0, 0);
        step(0, 1);
        n_chk++; if (state !== 2'b00 || cnt_clr !== 1'b1)
            $display("FAIL clear_cmd: got st=%b clr=%b want st=00 clr=1", state, cnt_clr);
        else n_pass++;
        n_chk++; if (int'(dut.pre) != m_elapsed % DIV) $display("FAIL clear_pre: got %0d want %0d", dut.pre, m_elapsed % DIV); else n_pass++;
        step(0, 0);
        n_chk++; if (cnt_clr !== 1'b0) $display("FAIL clear_one_cycle: got %b want 0", cnt_clr); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        step(1, 0);
        for (int i = 0; i < 8 && !seen; i++) begin
            step(0, 0);
            seen = cnt_inc;
        end
        n_chk++; if (!seen) $display("FAIL async_sync_timeout: got none want cnt_inc"); else n_pass++;
        rstb = 1'b0;
        #1;
        n_chk++; if (obs !== 6'b0) $display("FAIL async_reset: got %b want %b", obs, 6'b0); else n_pass++;
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            n_chk++; if (obs !== m_vec) $display("FAIL async_release: got %b want %b", obs, m_vec); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            n_chk++;
            if (obs !== m_vec || int'(dut.pre) != m_elapsed % DIV)
                $display("FAIL random[%0d]: got %b pre=%0d want %b pre=%0d", i, obs, dut.pre, m_vec, m_elapsed % DIV);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_lap();
        test_pause();
        test_simul_then_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
